// File: rtl/ofmap_wr_l7.sv
// Output-feature-map writer: walks x/y/u over one layer, turns each accepted
// result beat into a registered memory write with optional ReLU clamping.
module ofmap_wr_l7 #(
  parameter int MAP_W = 14,
  parameter int MAP_H = 14,
  parameter int N_GRP = 5,
  parameter int DW    = 16,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          hold,
  input  logic          relu_en,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [4:0]    x,
  output logic [4:0]    y,
  output logic [2:0]    u,
  output logic          row_done,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {IDLE, RUN, LAST} state_t;

  localparam logic [4:0] X_MAX = 5'(MAP_W - 1);
  localparam logic [4:0] Y_MAX = 5'(MAP_H - 1);
  localparam logic [2:0] U_MAX = 3'(N_GRP - 1);

  state_t state, state_nxt;

  logic                 accept;
  logic                 wrap_x, wrap_y, wrap_u;
  logic                 last_beat;
  logic [AW-1:0]        addr_p0;
  logic                 vld_p1;
  logic                 done_p1;
  logic [AW-1:0]        addr_p1;
  logic signed [DW-1:0] wdata_p1;

  function automatic logic signed [DW-1:0] relu_clamp(
    input logic signed [DW-1:0] d,
    input logic                 en
  );
    return (en && d[DW-1]) ? '0 : d;
  endfunction

  assign in_ready  = (state == RUN) && !hold;
  assign accept    = in_valid && in_ready;
  assign wrap_x    = (x == X_MAX);
  assign wrap_y    = (y == Y_MAX);
  assign wrap_u    = (u == U_MAX);
  assign last_beat = accept && wrap_x && wrap_y && wrap_u;
  assign row_done  = accept && wrap_x;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_beat) state_nxt = LAST;
      LAST:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: scan position and linear address counter (no multiply needed
  // because the scan order matches the memory layout u-major, then y, then x).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x       <= '0;
      y       <= '0;
      u       <= '0;
      addr_p0 <= '0;
    end else if (state == IDLE && start) begin
      x       <= '0;
      y       <= '0;
      u       <= '0;
      addr_p0 <= '0;
    end else if (accept) begin
      addr_p0 <= addr_p0 + 1'b1;
      x       <= wrap_x ? 5'd0 : x + 5'd1;
      if (wrap_x) y <= wrap_y ? 5'd0 : y + 5'd1;
      if (wrap_x && wrap_y) u <= wrap_u ? 3'd0 : u + 3'd1;
    end
  end

  // Stage p1: registered write port; address/data hold between writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1   <= 1'b0;
      done_p1  <= 1'b0;
      addr_p1  <= '0;
      wdata_p1 <= '0;
    end else begin
      vld_p1  <= accept;
      done_p1 <= last_beat;
      if (accept) begin
        addr_p1  <= addr_p0;
        wdata_p1 <= relu_clamp(in_data, relu_en);
      end
    end
  end

  assign mem_we    = vld_p1;
  assign mem_addr  = addr_p1;
  assign mem_wdata = wdata_p1;
  assign done      = done_p1;

endmodule
